// File: rtl/ws2812_frame_receiver.sv
// WS2812 chain receiver: decodes eight 24-bit GRB frames from a pulse-width
// encoded line, latches them on a reset gap and forwards surplus bits downstream.
//
// state | meaning
// SYNC  | waiting for a full reset gap before trusting the line
// IDLE  | between packets, indices cleared
// HIGH  | measuring a high pulse
// LOW   | measuring the low time after a pulse (next bit or latch gap)
module ws2812_frame_receiver #(
  parameter int BIT_THRESH   = 30,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2500,
  parameter int CNT_W        = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic        dout,
  output logic [23:0] frame_for_led0,
  output logic [23:0] frame_for_led1,
  output logic [23:0] frame_for_led2,
  output logic [23:0] frame_for_led3,
  output logic [23:0] frame_for_led4,
  output logic [23:0] frame_for_led5,
  output logic [23:0] frame_for_led6,
  output logic [23:0] frame_for_led7,
  output logic        frames_valid,
  output logic        frame_error,
  output logic [2:0]  no_of_frame_dbg,
  output logic [4:0]  bit_cnt_dbg
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

  logic             din_m;
  logic             din_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [22:0]      shift_q;
  logic [4:0]       bit_cnt;
  logic [2:0]       frame_idx;
  logic             saturated;
  logic [23:0]      shadow [8];
  logic [23:0]      frames [8];

  logic             bit_val;
  logic [23:0]      word;
  logic             low_done;
  logic             high_max;

  assign bit_val  = (high_cnt >= THRESH_C);
  assign word     = {shift_q, bit_val};
  assign low_done = (low_cnt == RESET_LAST);
  assign high_max = (high_cnt == HIGH_LAST);

  // Surplus bits beyond the eighth frame belong to the next device.
  assign dout = saturated & din_s;

  assign frame_for_led0  = frames[0];
  assign frame_for_led1  = frames[1];
  assign frame_for_led2  = frames[2];
  assign frame_for_led3  = frames[3];
  assign frame_for_led4  = frames[4];
  assign frame_for_led5  = frames[5];
  assign frame_for_led6  = frames[6];
  assign frame_for_led7  = frames[7];
  assign no_of_frame_dbg = frame_idx;
  assign bit_cnt_dbg     = bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_m        <= 1'b0;
      din_s        <= 1'b0;
      state        <= ST_SYNC;
      high_cnt     <= '0;
      low_cnt      <= '0;
      shift_q      <= '0;
      bit_cnt      <= '0;
      frame_idx    <= '0;
      saturated    <= 1'b0;
      frames_valid <= 1'b0;
      frame_error  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        frames[i] <= '0;
      end
    end else begin
      din_m        <= din;
      din_s        <= din_m;
      frames_valid <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_done) begin
            low_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (din_s) begin
            high_cnt <= CNT_ONE;
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (din_s) begin
            if (high_max) begin
              // Stuck-high line: drop everything and resynchronise on a clean gap.
              frame_error <= 1'b1;
              state       <= ST_SYNC;
              high_cnt    <= '0;
              low_cnt     <= '0;
              bit_cnt     <= '0;
              frame_idx   <= '0;
              saturated   <= 1'b0;
              for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
              end
            end else begin
              high_cnt <= high_cnt + CNT_ONE;
            end
          end else begin
            low_cnt <= CNT_ONE;
            state   <= ST_LOW;
            if (!saturated) begin
              if (bit_cnt == 5'd23) begin
                shadow[frame_idx] <= word;
                bit_cnt           <= '0;
                if (frame_idx == 3'd7) begin
                  saturated <= 1'b1;
                end else begin
                  frame_idx <= frame_idx + 3'd1;
                end
              end else begin
                shift_q <= word[22:0];
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
        end
        ST_LOW: begin
          if (din_s) begin
            high_cnt <= CNT_ONE;
            state    <= ST_HIGH;
          end else if (low_done) begin
            low_cnt   <= '0;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            frame_idx <= '0;
            saturated <= 1'b0;
            if (saturated && (bit_cnt == 5'd0)) begin
              frames       <= shadow;
              frames_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            low_cnt <= low_cnt + CNT_ONE;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_receiver.sv
// Bench for ws2812_frame_receiver: fixed packet scenarios, a table of packet
// lengths with random data, and a queue-based reference model of the line protocol.
module tb_ws2812_frame_receiver;

  localparam int BIT_THRESH   = 30;
  localparam int MAX_HIGH     = 60;
  localparam int RESET_CYCLES = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        dout;
  logic [23:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic        frames_valid;
  logic        frame_error;
  logic [2:0]  no_of_frame_dbg;
  logic [4:0]  bit_cnt_dbg;

  ws2812_frame_receiver #(
    .BIT_THRESH(BIT_THRESH), .MAX_HIGH(MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .frame_for_led0(led0), .frame_for_led1(led1), .frame_for_led2(led2),
    .frame_for_led3(led3), .frame_for_led4(led4), .frame_for_led5(led5),
    .frame_for_led6(led6), .frame_for_led7(led7),
    .frames_valid(frames_valid), .frame_error(frame_error),
    .no_of_frame_dbg(no_of_frame_dbg), .bit_cnt_dbg(bit_cnt_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n_bits;
    logic       exp_valid;
    logic       exp_err;
    logic [2:0] exp_idx;
    logic [4:0] exp_bcnt;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0, n_valid = 0, n_err = 0, n_both = 0, last_err_cyc = -1;
  int dmode = 0, dout_bad = 0, dout_hi = 0;
  logic hist1 = 1'b0, hist2 = 1'b0;

  logic [23:0] exp_frames [8];
  int          pulse_q [$];
  bit          model_sync;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    hist2 <= hist1;
    hist1 <= din;
  end

  always @(negedge clk) begin
    if (frames_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_error === 1'b1) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (frames_valid === 1'b1 && frame_error === 1'b1) n_both <= n_both + 1;
    if (dmode == 1 && dout !== 1'b0) dout_bad <= dout_bad + 1;
    if (dmode == 2) begin
      if (dout !== hist2) dout_bad <= dout_bad + 1;
      if (dout === 1'b1) dout_hi <= dout_hi + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] led(input int i);
    case (i)
      0: return led0;
      1: return led1;
      2: return led2;
      3: return led3;
      4: return led4;
      5: return led5;
      6: return led6;
      default: return led7;
    endcase
  endfunction

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      din = v;
    end
  endtask

  task automatic send_bit(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
    if (!model_sync) pulse_q.push_back(hi);
  endtask

  // Widths biased towards the 29/30 threshold and the 1/59 extremes.
  function automatic int rand_hi(input logic b);
    int k;
    k = $urandom_range(0, 3);
    if (b) return (k == 0) ? BIT_THRESH : (k == 1) ? MAX_HIGH - 1 : $urandom_range(BIT_THRESH, 40);
    return (k == 0) ? BIT_THRESH - 1 : (k == 1) ? 1 : $urandom_range(1, 10);
  endfunction

  task automatic send_rand_bits(input int n, output int sum_hi);
    int h;
    sum_hi = 0;
    for (int i = 0; i < n; i++) begin
      h = rand_hi(1'($urandom_range(0, 1)));
      sum_hi += h;
      send_bit(h, 2);
    end
  endtask

  // A packet is good only if at least 192 pulses arrived; later pulses are forwarded.
  task automatic model_latch(output int ev, output int ee);
    ev = 0;
    ee = 0;
    if (pulse_q.size() >= 192) begin
      for (int f = 0; f < 8; f++)
        for (int b = 0; b < 24; b++)
          exp_frames[f][23-b] = (pulse_q[f*24+b] >= BIT_THRESH);
      ev = 1;
    end else if (pulse_q.size() > 0) begin
      ee = 1;
    end
    pulse_q.delete();
  endtask

  task automatic check_leds(input string nm);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s led%0d", nm, i), 32'(led(i)), 32'(exp_frames[i]));
  endtask

  task automatic latch_check(input string nm, input int ev, input int ee);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    drive(1'b0, RESET_CYCLES + 10);
    chk({nm, " valid pulses"}, 32'(n_valid - v0), 32'(ev));
    chk({nm, " error pulses"}, 32'(n_err - e0), 32'(ee));
    check_leds(nm);
  endtask

  logic [23:0] spec_frames [8];
  vec_t        vecs [5];

  initial begin
    int ev, ee, s, b0, h0, e0, v0, t0;
    logic bv;

    spec_frames = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hA5A5A5,
                    24'h5A5A5A, 24'h000001, 24'h800000, 24'h123456};
    vecs[0] = '{n_bits: 1,   exp_valid: 1'b0, exp_err: 1'b1, exp_idx: 3'd0, exp_bcnt: 5'd1};
    vecs[1] = '{n_bits: 24,  exp_valid: 1'b0, exp_err: 1'b1, exp_idx: 3'd1, exp_bcnt: 5'd0};
    vecs[2] = '{n_bits: 120, exp_valid: 1'b0, exp_err: 1'b1, exp_idx: 3'd5, exp_bcnt: 5'd0};
    vecs[3] = '{n_bits: 191, exp_valid: 1'b0, exp_err: 1'b1, exp_idx: 3'd7, exp_bcnt: 5'd23};
    vecs[4] = '{n_bits: 192, exp_valid: 1'b1, exp_err: 1'b0, exp_idx: 3'd7, exp_bcnt: 5'd0};
    for (int i = 0; i < 8; i++) exp_frames[i] = '0;
    model_sync = 1'b1;

    // Reset state
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dout", 32'(dout), 0);
    chk("reset frames_valid", 32'(frames_valid), 0);
    chk("reset frame_error", 32'(frame_error), 0);
    chk("reset frame idx", 32'(no_of_frame_dbg), 0);
    chk("reset bit count", 32'(bit_cnt_dbg), 0);
    check_leds("reset");
    @(negedge clk);
    rst = 1'b0;

    // Pulses before the first gap must not decode
    repeat (3) send_bit(40, 22);
    drive(1'b0, 5);
    chk("pre-sync bit count", 32'(bit_cnt_dbg), 0);
    drive(1'b0, RESET_CYCLES + 10);
    model_sync = 1'b0;
    chk("pre-sync no error", 32'(n_err), 0);

    // Reference packet with nominal timing
    dmode = 1;
    for (int f = 0; f < 8; f++)
      for (int b = 23; b >= 0; b--) begin
        bv = spec_frames[f][b];
        if (bv) send_bit(40, 22);
        else    send_bit(20, 42);
      end
    model_latch(ev, ee);
    latch_check("ref packet", 1, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ref packet literal led%0d", i), 32'(led(i)), 32'(spec_frames[i]));
    dmode = 0;
    chk("dout low while not saturated", 32'(dout_bad), 0);

    // Saturated packet: 24 surplus bits forwarded on dout
    send_rand_bits(192, s);
    @(negedge clk);
    b0 = dout_bad;
    h0 = dout_hi;
    dmode = 2;
    send_rand_bits(24, s);
    model_latch(ev, ee);
    latch_check("saturated packet", ev, ee);
    dmode = 0;
    @(negedge clk);
    chk("dout follows line delayed 2", 32'(dout_bad - b0), 0);
    chk("dout forwarded high cycles", 32'(dout_hi - h0), 32'(s));

    // Packet length table
    foreach (vecs[k]) begin
      send_rand_bits(vecs[k].n_bits, s);
      drive(1'b0, 5);
      chk($sformatf("len%0d frame idx", vecs[k].n_bits), 32'(no_of_frame_dbg), 32'(vecs[k].exp_idx));
      chk($sformatf("len%0d bit count", vecs[k].n_bits), 32'(bit_cnt_dbg), 32'(vecs[k].exp_bcnt));
      model_latch(ev, ee);
      latch_check($sformatf("len%0d", vecs[k].n_bits), int'(vecs[k].exp_valid), int'(vecs[k].exp_err));
    end

    // Stuck-high pulse mid-frame
    send_rand_bits(10, s);
    e0 = n_err;
    v0 = n_valid;
    @(negedge clk);
    din = 1'b1;
    t0 = cyc;
    drive(1'b1, 79);
    pulse_q.delete();
    model_sync = 1'b1;
    drive(1'b0, 3);
    repeat (5) send_bit(40, 22);
    drive(1'b0, 5);
    chk("long pulse error count", 32'(n_err - e0), 1);
    chk("long pulse error timing", 32'(last_err_cyc - t0), 32'(2 + MAX_HIGH));
    chk("long pulse no decode bits", 32'(bit_cnt_dbg), 0);
    chk("long pulse no decode idx", 32'(no_of_frame_dbg), 0);
    drive(1'b0, RESET_CYCLES + 10);
    model_sync = 1'b0;
    chk("resync gap no error", 32'(n_err - e0), 1);
    chk("resync gap no valid", 32'(n_valid - v0), 0);
    check_leds("after long pulse");

    // Reset mid-packet, then a full packet
    e0 = n_err;
    send_rand_bits(100, s);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    pulse_q.delete();
    for (int i = 0; i < 8; i++) exp_frames[i] = '0;
    chk("mid reset bit count", 32'(bit_cnt_dbg), 0);
    chk("mid reset dout", 32'(dout), 0);
    check_leds("mid reset");
    rst = 1'b0;
    model_sync = 1'b1;
    drive(1'b0, RESET_CYCLES + 10);
    model_sync = 1'b0;
    send_rand_bits(192, s);
    model_latch(ev, ee);
    latch_check("post reset packet", ev, ee);
    chk("aborted packet no error", 32'(n_err - e0), 0);

    chk("valid/error overlap", 32'(n_both), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
